macc_frame_seq: RTL and testbench
=================================

Name: macc_frame_seq

Overview:
- Frame sequencer wrapped around the constant-coefficient MAC accumulator (a·29 accumulate, `sload` restart, 3-stage `ce`-gated pipeline).
- Accepts a valid/ready sample stream and drives the MAC's `a`, `ce` and `sload` so every FRAME_LEN samples form one accumulation.
- Flushes the MAC pipeline when input pauses, captures each frame's sum from `accum_out`, then rounds, shifts and saturates it into a one-entry valid/ready output register.
- Sits directly upstream of the MAC (feeds it) and directly downstream of it (consumes its result).

Parameters:
- SIZEIN, 16, sample width; equals MAC SIZEIN.
- SIZEOUT, 40, MAC accumulator width.
- FRAME_LEN, 8, samples per frame; legal range 1..1024.
- SHIFT, 4, arithmetic right shift applied to the frame sum; legal range 0..SIZEOUT-OUT_W.
- OUT_W, 16, result width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid&&in_ready
- in_data  in  SIZEIN  signed sample
- macc_ce  out  1  to MAC ce
- macc_sload  out  1  to MAC sload
- macc_a  out  SIZEIN  to MAC a
- macc_accum  in  SIZEOUT  from MAC accum_out
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  OUT_W  signed frame result

Behaviour:
- Reset: async assert, sync deassert. All outputs and state are 0: out_valid=0, out_data=0, macc_ce=0, macc_sload=0, macc_a=0, cnt=0, tags=0, sload_next=0. MAC contents are not cleared; the first frame's sload discards them.
- Block condition: `cap_blk` = cap_pend && out_valid && !out_ready.
- Accept: in_ready = !cap_blk. On accept: macc_ce=1, macc_a=in_data (combinational pass-through).
- Flush: if no accept, !cap_blk and (t1||t2), drive macc_ce=1, macc_a=0. A flush cycle is a ce-cycle.
- Idle: otherwise macc_ce=0.
- sload alignment: the MAC clears on the ce-edge two after the sample's edge, using the sload from the next ce-cycle.
  - Accepting a frame's first sample (cnt==0) sets sload_next.
  - macc_sload = sload_next on any ce-cycle (real or flush); sload_next clears on that ce-edge.
  - FRAME_LEN=1: the flush cycle carries sload=1.
- Frame counter cnt: 0..FRAME_LEN-1, increments on accept, wraps to 0 on the last sample. Flush cycles do not count.
- Tag pipeline, advancing only on ce-edges:
  - t1 <= accept of last sample;
  - t2 <= t1;
  - cap_pend set when t2 advances.
  - The next frame may follow back-to-back; tags are independent per slot.
- Capture:
  - When cap_pend && (!out_valid || out_ready), on the next edge: out_data <= sat(round(macc_accum)), out_valid <= 1, cap_pend <= 0.
  - The same edge may also be a ce-edge; the pre-edge accum_out is used.
  - While cap_blk, macc_ce=0 so the sum is held.
- Arithmetic: round = macc_accum + (SHIFT>0 ? 1<<(SHIFT-1) : 0), done in SIZEOUT+1 bits, then >>> SHIFT. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output: out_valid clears on out_ready without a new capture. out_data is held while out_valid && !out_ready.
- Latency: last sample accepted at edge e → out_valid at edge e+3, if unstalled.
- Reset mid-frame: partial frame and pending result are discarded; the next accepted sample is frame start.

Optional Feature:
- Macro MACC_FRAME_SEQ_SATFLAG_EN.
- Defined: extra output sat_flag (1 bit), registered with out_data. It is 1 if the captured result was clipped, reset 0.
- Undefined: port absent; clipping is silent.

Decomposition:
- Package macc_seq_pkg holds:
  - localparam CNT_W = $clog2(FRAME_LEN) (min 1);
  - the rounding constant function;
  - the saturation limit constants.
- One natural sub-module, macc_round_sat: combinational round, shift and saturate, plus sat flag.
- Everything else stays in macc_frame_seq.
- Bench instantiates macc_frame_seq together with the real MAC.

Test Plan:
- FRAME_LEN=8, SHIFT=0, OUT_W=16, continuous samples 1..8, out_ready=1 → out_data=29·36=1044, out_valid 3 cycles after the 8th accept.
- Two back-to-back frames (all 1s, then all 2s) → 232 then 464; no cross-frame leakage.
- Frame of 8 with in_valid gaps, then idle → flush cycles drive macc_a=0; result 1044; sload pulses exactly once per frame.
- Hold out_ready=0 across three frames → in_ready drops, first result held, no value lost or duplicated when out_ready returns.
- Samples 32767×8 with SHIFT=4, OUT_W=16 → 29·262136>>4 = 475121 saturates to 32767 (sat_flag=1 if enabled). Negative counterpart gives -32768.
- Assert rst_n at sample 5 of a frame → outputs 0 immediately; the next frame of 1..8 yields 1044.

Source files
------------

// File: rtl/macc_seq_pkg.sv
// macc_seq_pkg: shared widths, rounding constant and saturation limits for
// the MAC frame sequencer and its round/saturate stage.
package macc_seq_pkg;

  // Default frame length and the counter width that goes with it.
  localparam int FRAME_LEN_DEF = 8;

  // Counter width for a given frame length; never narrower than one bit.
  function automatic int cntWidth(input int frameLen);
    return (frameLen <= 2) ? 1 : $clog2(frameLen);
  endfunction

  localparam int CNT_W = cntWidth(FRAME_LEN_DEF);

  // Half-LSB of the shifted result, added before the arithmetic shift.
  function automatic longint roundConst(input int shift);
    return (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
  endfunction

  // Largest positive value representable in an outW-bit signed result.
  function automatic longint satMaxVal(input int outW);
    return (64'sd1 <<< (outW - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in an outW-bit signed result.
  function automatic longint satMinVal(input int outW);
    return -(64'sd1 <<< (outW - 1));
  endfunction

endpackage

// File: rtl/macc_round_sat.sv
// macc_round_sat: combinational round-half-up, arithmetic shift and signed
// saturation of a MAC frame sum.
// Optional: MACC_FRAME_SEQ_SATFLAG_EN adds the o_sat clip indicator.
module macc_round_sat
  import macc_seq_pkg::*;
#(
  parameter int SIZEOUT = 40,
  parameter int SHIFT   = 4,
  parameter int OUT_W   = 16
) (
  input  logic signed [SIZEOUT-1:0] i_accum,
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  output logic                      o_sat,
`endif
  output logic signed [OUT_W-1:0]   o_result
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [SIZEOUT:0] RND  = (SIZEOUT+1)'(roundConst(SHIFT));
  localparam logic signed [SIZEOUT:0] MAXV = (SIZEOUT+1)'(satMaxVal(OUT_W));
  localparam logic signed [SIZEOUT:0] MINV = (SIZEOUT+1)'(satMinVal(OUT_W));

  logic signed [SIZEOUT:0] w_rounded;
  logic signed [SIZEOUT:0] w_shifted;
  logic                    w_clip;

  // Round, shift, then clamp into the output range.
  always_comb begin
    w_rounded = {i_accum[SIZEOUT-1], i_accum} + RND;
    w_shifted = w_rounded >>> SHIFT;
    w_clip    = 1'b0;
    o_result  = w_shifted[OUT_W-1:0];
    if (w_shifted > MAXV) begin
      o_result = MAXV[OUT_W-1:0];
      w_clip   = 1'b1;
    end else if (w_shifted < MINV) begin
      o_result = MINV[OUT_W-1:0];
      w_clip   = 1'b1;
    end
  end

`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  assign o_sat = w_clip;
`endif

endmodule

// File: rtl/macc_frame_seq.sv
// macc_frame_seq: groups a valid/ready sample stream into FRAME_LEN-sample
// accumulations on a 3-stage constant-coefficient MAC, flushes the MAC
// pipeline when input pauses, and delivers each rounded/saturated frame sum
// through a one-entry valid/ready output register.
// Optional: MACC_FRAME_SEQ_SATFLAG_EN adds the sat_flag output.
module macc_frame_seq
  import macc_seq_pkg::*;
#(
  parameter int SIZEIN    = 16,
  parameter int SIZEOUT   = 40,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int SHIFT     = 4,
  parameter int OUT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SIZEIN-1:0]  in_data,
  output logic               macc_ce,
  output logic               macc_sload,
  output logic [SIZEIN-1:0]  macc_a,
  input  logic [SIZEOUT-1:0] macc_accum,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  output logic               sat_flag,
`endif
  output logic [OUT_W-1:0]   out_data
);

  // The default frame length reuses the package width; others derive their own.
  localparam int CNT_WIDTH = (FRAME_LEN == FRAME_LEN_DEF) ? CNT_W : cntWidth(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sloadNext;
  logic                 r_t1;
  logic                 r_t2;
  logic                 r_capPend;
  logic                 r_outValid;
  logic [OUT_W-1:0]     r_outData;
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  logic                 r_satFlag;
  logic                 w_sat;
`endif

  logic             w_capBlk;
  logic             w_accept;
  logic             w_flush;
  logic             w_ce;
  logic             w_last;
  logic             w_capture;
  logic [OUT_W-1:0] w_result;

  // Per-cycle decisions: stall on a blocked capture, else accept or flush.
  // Nothing is accepted while reset is held so the MAC drive stays at zero.
  always_comb begin
    w_capBlk  = r_capPend && r_outValid && !out_ready;
    w_accept  = rst_n && in_valid && !w_capBlk;
    w_flush   = rst_n && !w_accept && !w_capBlk && (r_t1 || r_t2);
    w_ce      = w_accept || w_flush;
    w_last    = (r_cnt == LAST_CNT);
    w_capture = r_capPend && (!r_outValid || out_ready);
  end

  assign in_ready   = rst_n && !w_capBlk;
  assign macc_ce    = w_ce;
  assign macc_a     = w_accept ? in_data : '0;
  assign macc_sload = w_ce && r_sloadNext;
  assign out_valid  = r_outValid;
  assign out_data   = r_outData;
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  assign sat_flag   = r_satFlag;
`endif

  // Sample position within the frame; only accepted samples count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Arm sload on a frame's first sample; it rides out on the following ce-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sloadNext <= 1'b0;
    end else if (w_accept && (r_cnt == '0)) begin
      r_sloadNext <= 1'b1;
    end else if (w_ce) begin
      r_sloadNext <= 1'b0;
    end
  end

  // End-of-frame tag tracks the last sample through the MAC pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= 1'b0;
      r_t2 <= 1'b0;
    end else if (w_ce) begin
      r_t1 <= w_accept && w_last;
      r_t2 <= r_t1;
    end
  end

  // A finished sum waits here until the output register can take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capPend <= 1'b0;
    end else if (w_ce && r_t2) begin
      r_capPend <= 1'b1;
    end else if (w_capture) begin
      r_capPend <= 1'b0;
    end
  end

  // One-entry output register, loaded from the pre-edge MAC sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
      r_satFlag  <= 1'b0;
`endif
    end else if (w_capture) begin
      r_outValid <= 1'b1;
      r_outData  <= w_result;
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
      r_satFlag  <= w_sat;
`endif
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  macc_round_sat #(
    .SIZEOUT (SIZEOUT),
    .SHIFT   (SHIFT),
    .OUT_W   (OUT_W)
  ) u_roundSat (
    .i_accum  (macc_accum),
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    .o_sat    (w_sat),
`endif
    .o_result (w_result)
  );

endmodule

// File: tb/tb_macc_frame_seq.sv
// tb_macc_frame_seq: two sequencers (SHIFT=0 and SHIFT=4) driven by the same
// sample stream, each feeding its own a*29 three-stage MAC, with directed
// frames and hand-computed frame results.
// Optional: MACC_FRAME_SEQ_SATFLAG_EN also checks sat_flag.
module tb_macc_frame_seq;

  logic               clk = 1'b0;
  logic               rstN = 1'b1;
  logic               inValid = 1'b0;
  logic signed [15:0] inData = 16'sd0;
  logic               outReady = 1'b1;

  logic               inReadyA, maccCeA, maccSloadA, outValidA;
  logic signed [15:0] maccAA, outDataA;
  logic               inReadyB, maccCeB, maccSloadB, outValidB;
  logic signed [15:0] maccAB, outDataB;
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
  logic               satFlagA, satFlagB;
  logic               satA[$], satB[$];
  int                 satBase;
`endif

  // MAC state starts with junk so the first frame's sload has to clear it.
  logic signed [15:0] macARegA = 16'sd5,   macARegB = 16'sd5;
  logic               macSloadRegA = 1'b0, macSloadRegB = 1'b0;
  logic signed [39:0] macMultA = 40'sd99,  macMultB = 40'sd99;
  logic signed [39:0] macAdderA = 40'sd777, macAdderB = 40'sd777;

  int                 testCount = 0;
  int                 failCount = 0;
  logic signed [15:0] resA[$], resB[$];
  int                 rdIdx = 0;
  int                 sloadCount = 0, flushCount = 0, flushBad = 0;
  int                 s0, f0, b0;
  logic signed [15:0] stim[$];

  always #5 clk = ~clk;

  macc_frame_seq #(.SIZEIN(16), .SIZEOUT(40), .FRAME_LEN(8), .SHIFT(0), .OUT_W(16)) dutA (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyA), .in_data(inData),
    .macc_ce(maccCeA), .macc_sload(maccSloadA), .macc_a(maccAA), .macc_accum(macAdderA),
    .out_valid(outValidA), .out_ready(outReady),
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    .sat_flag(satFlagA),
`endif
    .out_data(outDataA)
  );

  macc_frame_seq #(.SIZEIN(16), .SIZEOUT(40), .FRAME_LEN(8), .SHIFT(4), .OUT_W(16)) dutB (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
    .macc_ce(maccCeB), .macc_sload(maccSloadB), .macc_a(maccAB), .macc_accum(macAdderB),
    .out_valid(outValidB), .out_ready(outReady),
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    .sat_flag(satFlagB),
`endif
    .out_data(outDataB)
  );

  // Constant-coefficient MACs: a register, a*29 product, accumulate with sload restart.
  always @(posedge clk) begin
    if (maccCeA) begin
      macARegA     <= maccAA;
      macSloadRegA <= maccSloadA;
      macMultA     <= macARegA * 40'sd29;
      macAdderA    <= (macSloadRegA ? 40'sd0 : macAdderA) + macMultA;
    end
    if (maccCeB) begin
      macARegB     <= maccAB;
      macSloadRegB <= maccSloadB;
      macMultB     <= macARegB * 40'sd29;
      macAdderB    <= (macSloadRegB ? 40'sd0 : macAdderB) + macMultB;
    end
  end

  // Record delivered results and MAC drive activity between clock edges.
  always @(negedge clk) begin
    if (outValidA && outReady) resA.push_back(outDataA);
    if (outValidB && outReady) resB.push_back(outDataB);
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    if (outValidA && outReady) satA.push_back(satFlagA);
    if (outValidB && outReady) satB.push_back(satFlagB);
`endif
    if (maccCeA && maccSloadA) sloadCount++;
    if (maccCeA && !(inValid && inReadyA)) begin
      flushCount++;
      if (maccAA != 16'sd0) flushBad++;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  function automatic void addRamp(input int sign);
    for (int i = 1; i <= 8; i++) stim.push_back(16'(sign * i));
  endfunction

  function automatic void addConst(input int v, input int n);
    for (int i = 0; i < n; i++) stim.push_back(16'(v));
  endfunction

  // Stream the queued samples, honouring in_ready; optional idle gaps mid-frame.
  task automatic applyStimulus(input bit gaps);
    int waitCycles;
    foreach (stim[i]) begin
      if (gaps && (i % 3 == 1)) begin
        inValid = 1'b0;
        @(posedge clk); #1;
      end
      inValid = 1'b1;
      inData  = stim[i];
      waitCycles = 0;
      while (inReadyA !== 1'b1 && waitCycles < 300) begin
        @(posedge clk); #1;
        waitCycles++;
      end
      checkOutput("in_ready_wait", inReadyA, 1);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    stim.delete();
  endtask

  // Wait (bounded) for the next delivered result of both DUTs and compare.
  task automatic expectResult(input string tag, input int expA, input int expB);
    int waitCycles = 0;
    while ((resA.size() <= rdIdx || resB.size() <= rdIdx) && waitCycles < 200) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput({tag, "_avail"}, (resA.size() > rdIdx && resB.size() > rdIdx), 1);
    if (resA.size() > rdIdx && resB.size() > rdIdx) begin
      checkOutput({tag, "_a"}, resA[rdIdx], expA);
      checkOutput({tag, "_b"}, resB[rdIdx], expB);
      rdIdx++;
    end
  endtask

  initial begin
    #2 rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_out_data_a", outDataA, 0);
    checkOutput("rst_out_data_b", outDataB, 0);
    checkOutput("rst_macc_ce", maccCeA, 0);
    checkOutput("rst_macc_sload", maccSloadA, 0);
    checkOutput("rst_macc_a", maccAA, 0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", inReadyA, 1);

    $display("[TB] single frame 1..8 and latency");
    addRamp(1);
    applyStimulus(1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("lat_early", outValidA, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid", outValidA, 1);
    checkOutput("lat_data", outDataA, 1044);
    expectResult("ramp", 1044, 65);

    $display("[TB] back-to-back frames");
    addConst(1, 8);
    addConst(2, 8);
    applyStimulus(1'b0);
    expectResult("b2b_ones", 232, 15);
    expectResult("b2b_twos", 464, 29);

    $display("[TB] frame with input gaps");
    s0 = sloadCount; f0 = flushCount; b0 = flushBad;
    addRamp(1);
    applyStimulus(1'b1);
    expectResult("gap", 1044, 65);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("gap_sload_count", sloadCount - s0, 1);
    checkOutput("gap_flush_count", flushCount - f0, 2);
    checkOutput("gap_flush_data", flushBad - b0, 0);

    $display("[TB] saturation boundaries");
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    satBase = rdIdx;
`endif
    addConst(141, 7);
    addConst(142, 1);
    addConst(32767, 8);
    addConst(-32768, 8);
    addRamp(-1);
    applyStimulus(1'b0);
    expectResult("near_max", 32741, 2046);
    expectResult("sat_pos", 32767, 32767);
    expectResult("sat_neg", -32768, -32768);
    expectResult("neg_ramp", -1044, -65);
`ifdef MACC_FRAME_SEQ_SATFLAG_EN
    if (satA.size() >= satBase + 4 && satB.size() >= satBase + 4) begin
      checkOutput("satf_near_a", satA[satBase], 0);
      checkOutput("satf_pos_a", satA[satBase + 1], 1);
      checkOutput("satf_neg_a", satA[satBase + 2], 1);
      checkOutput("satf_ramp_a", satA[satBase + 3], 0);
      checkOutput("satf_near_b", satB[satBase], 0);
      checkOutput("satf_pos_b", satB[satBase + 1], 1);
      checkOutput("satf_neg_b", satB[satBase + 2], 1);
      checkOutput("satf_ramp_b", satB[satBase + 3], 0);
    end else begin
      checkOutput("satf_count", satA.size(), satBase + 4);
    end
`endif

    $display("[TB] output stalled across three frames");
    outReady = 1'b0;
    addConst(1, 8);
    addRamp(1);
    addConst(2, 8);
    fork
      applyStimulus(1'b0);
      begin
        repeat (60) @(posedge clk);
        #1;
        checkOutput("stall_in_ready_a", inReadyA, 0);
        checkOutput("stall_in_ready_b", inReadyB, 0);
        checkOutput("stall_out_valid", outValidA, 1);
        checkOutput("stall_hold_a", outDataA, 232);
        checkOutput("stall_hold_b", outDataB, 15);
        checkOutput("stall_ce_off", maccCeA, 0);
        outReady = 1'b1;
      end
    join
    expectResult("stall_f1", 232, 15);
    expectResult("stall_f2", 1044, 65);
    expectResult("stall_f3", 464, 29);
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("stall_no_dup", resA.size(), rdIdx);

    $display("[TB] reset in the middle of a frame");
    for (int i = 1; i <= 4; i++) stim.push_back(16'(i));
    applyStimulus(1'b0);
    inValid = 1'b1;
    inData  = 16'sd5;
    #1;
    checkOutput("pre_rst_ce", maccCeA, 1);
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_ce", maccCeA, 0);
    checkOutput("mid_rst_a", maccAA, 0);
    checkOutput("mid_rst_sload", maccSloadA, 0);
    checkOutput("mid_rst_valid", outValidA, 0);
    checkOutput("mid_rst_data_a", outDataA, 0);
    checkOutput("mid_rst_data_b", outDataB, 0);
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    addRamp(1);
    applyStimulus(1'b0);
    expectResult("post_rst", 1044, 65);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
